// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 keyboard read port: receiver state encoding,
// output word width and the frame-validity rule.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_t;

  localparam logic [3:0] PS2_DEV_ADDR_NIBBLE = 4'hD;
  localparam int         PS2_OUT_W           = 9;
  localparam int         PS2_CODE_W          = 8;

  // A frame is accepted only with a high stop bit and odd parity over code+parity.
  function automatic logic frame_ok(input logic [PS2_CODE_W-1:0] code,
                                    input logic                  par,
                                    input logic                  stop);
    return stop & (^{code, par});
  endfunction

endpackage

// File: rtl/ps2_kbd_port_if.sv
// Bus/board-side signal bundle of the PS/2 keyboard port; the port itself takes
// the slave view, the bus decoder and board pins take the master view.
interface ps2_kbd_port_if import ps2_pkg::*; #(
  parameter int FIFO_DEPTH = 8
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic                 ps2_clk;
  logic                 ps2_data;
  logic                 rd_ack;
  logic                 clr_ovf;
  logic [PS2_OUT_W-1:0] ps2_out;
  logic                 frame_err;
  logic                 overflow;
  logic [CW-1:0]        fifo_count;

  modport master (
    output ps2_clk, ps2_data, rd_ack, clr_ovf,
    input  ps2_out, frame_err, overflow, fifo_count
  );

  modport slave (
    input  ps2_clk, ps2_data, rd_ack, clr_ovf,
    output ps2_out, frame_err, overflow, fifo_count
  );

endinterface

// File: rtl/ps2_fifo.sv
// Scan-code FIFO with wrap-bit pointers; a pop frees a slot for a push in the
// same cycle, and pop on empty is ignored.
module ps2_fifo import ps2_pkg::*; #(
  parameter  int DEPTH  = 8,
  parameter  int DATA_W = PS2_CODE_W,
  localparam int AW     = $clog2(DEPTH),
  localparam int CW     = AW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              empty,
  output logic              full,
  output logic [CW-1:0]     count
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [CW-1:0]     r_wptr;
  logic [CW-1:0]     r_rptr;
  logic              w_pop_ok;
  logic              w_push_ok;

  assign empty     = (r_wptr == r_rptr);
  assign full      = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign count     = r_wptr - r_rptr;
  assign dout      = r_mem[r_rptr[AW-1:0]];
  assign w_pop_ok  = pop & ~empty;
  assign w_push_ok = push & (~full | w_pop_ok);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + 1'b1;
      if (w_pop_ok)  r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/ps2_kbd_port.sv
// PS/2 device-to-host receiver feeding a scan-code FIFO; presents {valid, code}
// for CPU reads and pops one code per read strobe.
module ps2_kbd_port import ps2_pkg::*; #(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input logic           clk,
  input logic           rst,
  ps2_kbd_port_if.slave bus
);

  localparam int              CW       = $clog2(FIFO_DEPTH) + 1;
  localparam int              TW       = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic                  r_clk_p0, r_clk_p1, r_clk_p2;
  logic                  r_dat_p0, r_dat_p1;
  ps2_state_t            r_state;
  logic [PS2_CODE_W-1:0] r_shift;
  logic [2:0]            r_bitcnt;
  logic                  r_parity;
  logic [TW-1:0]         r_tmo;
  logic                  r_frame_err;
  logic                  r_ovf;

  logic                  w_fe;
  logic                  w_push;
  logic                  w_ovf_evt;
  logic [PS2_CODE_W-1:0] w_dout;
  logic                  w_empty;
  logic                  w_full;
  logic [CW-1:0]         w_count;

  // stage p0/p1: metastability filter; p2: previous clock level for edge detect
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_clk_p0 <= 1'b1;
      r_clk_p1 <= 1'b1;
      r_clk_p2 <= 1'b1;
      r_dat_p0 <= 1'b1;
      r_dat_p1 <= 1'b1;
    end else begin
      r_clk_p0 <= bus.ps2_clk;
      r_clk_p1 <= r_clk_p0;
      r_clk_p2 <= r_clk_p1;
      r_dat_p0 <= bus.ps2_data;
      r_dat_p1 <= r_dat_p0;
    end
  end

  assign w_fe   = r_clk_p2 & ~r_clk_p1;
  assign w_push = w_fe && (r_state == STOP) && frame_ok(r_shift, r_parity, r_dat_p1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_shift     <= '0;
      r_bitcnt    <= '0;
      r_parity    <= 1'b0;
      r_tmo       <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      if (w_fe) begin
        r_tmo <= '0;
        unique case (r_state)
          IDLE: begin
            if (!r_dat_p1) begin
              r_state  <= DATA;
              r_bitcnt <= '0;
            end
          end
          DATA: begin
            r_shift  <= {r_dat_p1, r_shift[PS2_CODE_W-1:1]};
            r_bitcnt <= r_bitcnt + 3'd1;
            if (r_bitcnt == 3'd7) r_state <= PARITY;
          end
          PARITY: begin
            r_parity <= r_dat_p1;
            r_state  <= STOP;
          end
          STOP: begin
            if (!frame_ok(r_shift, r_parity, r_dat_p1)) r_frame_err <= 1'b1;
            r_state <= IDLE;
          end
        endcase
      end else if (r_state != IDLE) begin
        // a stalled device abandons the partial frame
        if (r_tmo == TMO_LAST) begin
          r_state     <= IDLE;
          r_frame_err <= 1'b1;
          r_tmo       <= '0;
          r_bitcnt    <= '0;
          r_shift     <= '0;
        end else begin
          r_tmo <= r_tmo + 1'b1;
        end
      end
    end
  end

  // a full FIFO still accepts a push when the same cycle pops
  assign w_ovf_evt = w_push & w_full & ~bus.rd_ack;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            r_ovf <= 1'b0;
    else if (w_ovf_evt) r_ovf <= 1'b1;
    else if (bus.clr_ovf) r_ovf <= 1'b0;
  end

  ps2_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (PS2_CODE_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (bus.rd_ack),
    .din   (r_shift),
    .dout  (w_dout),
    .empty (w_empty),
    .full  (w_full),
    .count (w_count)
  );

  assign bus.ps2_out    = w_empty ? '0 : {1'b1, w_dout};
  assign bus.frame_err  = r_frame_err;
  assign bus.overflow   = r_ovf;
  assign bus.fifo_count = w_count;

endmodule

// File: tb/tb_ps2_kbd_port.sv
// Directed bench for ps2_kbd_port: bit-banged PS/2 frames, bus pops and
// overflow handling checked against hand-computed values.
module tb_ps2_kbd_port;

  localparam int DEPTH = 8;
  localparam int TMO   = 400;

  logic clk;
  logic rst;
  int   n_chk  = 0;
  int   n_pass = 0;
  int   err_hi = 0;
  int   err_rise = 0;
  logic err_prev = 1'b0;

  ps2_kbd_port_if #(.FIFO_DEPTH(DEPTH)) bus ();

  ps2_kbd_port #(
    .FIFO_DEPTH     (DEPTH),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.frame_err) err_hi <= err_hi + 1;
    if (bus.frame_err && !err_prev) err_rise <= err_rise + 1;
    err_prev <= bus.frame_err;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    bus.ps2_data = b;
    cyc(4);
    bus.ps2_clk = 1'b0;
    cyc(8);
    bus.ps2_clk = 1'b1;
    cyc(8);
  endtask

  task automatic send_head(input logic [7:0] code, input logic par);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(code[i]);
    send_bit(par);
  endtask

  // stop bit; optionally raise rd_ack during the cycle in which the push happens
  task automatic send_stop(input logic ack);
    bus.ps2_data = 1'b1;
    cyc(4);
    bus.ps2_clk = 1'b0;
    cyc(2);
    if (ack) bus.rd_ack = 1'b1;
    cyc(1);
    bus.rd_ack = 1'b0;
    cyc(5);
    bus.ps2_clk = 1'b1;
    cyc(8);
  endtask

  task automatic send_frame(input logic [7:0] code, input logic par);
    send_head(code, par);
    send_stop(1'b0);
  endtask

  task automatic pop();
    bus.rd_ack = 1'b1;
    cyc(1);
    bus.rd_ack = 1'b0;
  endtask

  function automatic logic odd_par(input logic [7:0] c);
    return ~(^c);
  endfunction

  int e0;
  logic [7:0] drain_exp [8];

  initial begin
    drain_exp = '{8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h0A};
    rst = 1'b1;
    bus.ps2_clk = 1'b1; bus.ps2_data = 1'b1; bus.rd_ack = 1'b0; bus.clr_ovf = 1'b0;
    cyc(3);
    rst = 1'b0;
    cyc(3);
    chk("rst_out", 32'(bus.ps2_out), 32'h000);
    chk("rst_err", 32'(bus.frame_err), 0);
    chk("rst_ovf", 32'(bus.overflow), 0);
    chk("rst_cnt", 32'(bus.fifo_count), 0);

    // good frame 0x1C with exact valid latency after the stop-bit edge
    send_head(8'h1C, 1'b0);
    bus.ps2_data = 1'b1;
    cyc(4);
    bus.ps2_clk = 1'b0;
    cyc(2);
    chk("good_before_push", 32'(bus.ps2_out), 32'h000);
    cyc(1);
    chk("good_out", 32'(bus.ps2_out), 32'h11C);
    chk("good_cnt", 32'(bus.fifo_count), 1);
    cyc(5);
    bus.ps2_clk = 1'b1;
    cyc(8);
    pop();
    chk("good_pop_out", 32'(bus.ps2_out), 32'h000);
    chk("good_pop_cnt", 32'(bus.fifo_count), 0);

    // bad parity
    e0 = err_hi;
    send_frame(8'h1C, 1'b1);
    cyc(2);
    chk("badpar_err_cycles", 32'(err_hi - e0), 1);
    chk("badpar_out", 32'(bus.ps2_out), 32'h000);
    chk("badpar_cnt", 32'(bus.fifo_count), 0);
    send_frame(8'hF0, 1'b1);
    chk("f0_out", 32'(bus.ps2_out), 32'h1F0);
    pop();
    chk("f0_pop", 32'(bus.ps2_out), 32'h000);

    // timeout after start + 5 data bits
    e0 = err_hi;
    send_bit(1'b0);
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    cyc(TMO + 20);
    chk("tmo_err_cycles", 32'(err_hi - e0), 1);
    chk("tmo_out", 32'(bus.ps2_out), 32'h000);
    send_frame(8'h5A, 1'b1);
    chk("tmo_5a_out", 32'(bus.ps2_out), 32'h15A);

    // asynchronous reset mid-frame with a code already buffered
    e0 = err_hi;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b0);
    rst = 1'b1;
    #1;
    chk("midrst_out", 32'(bus.ps2_out), 32'h000);
    chk("midrst_cnt", 32'(bus.fifo_count), 0);
    cyc(3);
    rst = 1'b0;
    cyc(3);
    send_frame(8'h29, 1'b0);
    chk("midrst_29_out", 32'(bus.ps2_out), 32'h129);
    chk("midrst_no_err", 32'(err_hi - e0), 0);
    pop();
    chk("midrst_pop", 32'(bus.fifo_count), 0);

    // fill past full, then simultaneous push and pop
    for (int c = 1; c <= 9; c++) send_frame(8'(c), odd_par(8'(c)));
    chk("full_cnt", 32'(bus.fifo_count), 8);
    chk("full_ovf", 32'(bus.overflow), 1);
    chk("full_head", 32'(bus.ps2_out), 32'h101);
    send_head(8'h0A, odd_par(8'h0A));
    send_stop(1'b1);
    chk("pp_cnt", 32'(bus.fifo_count), 8);
    chk("pp_head", 32'(bus.ps2_out), 32'h102);
    chk("pp_ovf", 32'(bus.overflow), 1);
    bus.clr_ovf = 1'b1;
    cyc(1);
    bus.clr_ovf = 1'b0;
    chk("clr_ovf", 32'(bus.overflow), 0);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("drain%0d", i), 32'(bus.ps2_out), {23'd0, 1'b1, drain_exp[i]});
      pop();
    end
    pop();
    chk("empty_rd_out", 32'(bus.ps2_out), 32'h000);
    chk("empty_rd_cnt", 32'(bus.fifo_count), 0);
    chk("err_never_double", 32'(err_hi), 32'(err_rise));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ps2_kbd_port.md
Name: ps2_kbd_port

Overview:
- Bus-side responder for the PS/2 keyboard read slot at 0xD0000000.
- Deserialises PS/2 device-to-host frames into 8-bit scan codes and buffers them in a small FIFO.
- Presents {valid, code} as a 9-bit word for CPU reads; each bus read strobe consumes one code.
- Sits between the board PS/2 pins and the bus decoder's PS2_data input.

Parameters:
- FIFO_DEPTH, 8, number of buffered scan codes; power of two, at least 2.
- TIMEOUT_CYCLES, 50000, maximum idle clk cycles between PS/2 falling edges inside a frame.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous active-high reset.
- ps2_clk  input  1  raw PS/2 clock pin; asynchronous to clk.
- ps2_data  input  1  raw PS/2 data pin; asynchronous to clk.
- rd_ack  input  1  one-cycle pop strobe, asserted by the bus on a CPU read of 0xD0000000.
- clr_ovf  input  1  one-cycle strobe that clears the overflow flag.
- ps2_out  output  9  {valid, code[7:0]}; valid = FIFO non-empty, code = FIFO head; 9'h000 when empty.
- frame_err  output  1  one-cycle pulse when a frame is discarded.
- overflow  output  1  sticky flag: a good frame was dropped because the FIFO was full.
- fifo_count  output  clog2(FIFO_DEPTH)+1  current occupancy.

Behaviour:
- Reset: async on rst high. Synchronisers load 1; FSM goes to IDLE; shift register, bit counter, timeout counter and FIFO pointers clear. ps2_out=0, frame_err=0, overflow=0, fifo_count=0.
- Input sync: ps2_clk and ps2_data each pass through a 2-flop synchroniser. A falling edge (fe) is a 1-cycle pulse when the previous synchronised clk is 1 and the current one is 0. Data is sampled in the fe cycle.
- Frame format: start 0, D0..D7 LSB first, odd parity, stop 1.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on fe, if data=0 go to DATA with bitcnt=0; if data=1 stay in IDLE (no error).
  - DATA: on fe, shift data into bit [7] (right shift) and increment bitcnt; after the 8th bit go to PARITY.
  - PARITY: on fe, latch the parity bit and go to STOP.
  - STOP: on fe, a frame is good if stop=1 and ^{code,parity}=1. Good: push the code. Bad: pulse frame_err. Either way return to IDLE.
- Timeout: the counter resets on every fe and runs only outside IDLE. If it reaches TIMEOUT_CYCLES-1, go to IDLE, pulse frame_err and discard partial bits.
- Push timing: the FIFO write happens on the clock edge ending the stop-bit fe cycle. ps2_out.valid is high from the next cycle.
- Pop: rd_ack with FIFO non-empty advances the read pointer at the clock edge. rd_ack while empty is ignored and pointers stay unchanged.
- ps2_out is combinational from the FIFO head; it has no extra register stage.
- Full:
  - Push without pop: drop the code, set overflow, head unchanged.
  - Push and rd_ack in the same cycle: pop then push; count stays FIFO_DEPTH; no overflow.
- Empty, push and rd_ack in the same cycle: the pop is ignored and the push is stored, so count becomes 1.
- Overflow: clr_ovf clears the flag. If clr_ovf and a new overflow event occur in the same cycle, set wins.
- Pointers are clog2(FIFO_DEPTH)+1 bits and wrap modulo 2*FIFO_DEPTH. Full = MSBs differ and remaining bits are equal.
- frame_err never asserts for two consecutive cycles from a single frame.

Decomposition:
- Shared package ps2_pkg:
  - FSM state encoding (IDLE=0, DATA=1, PARITY=2, STOP=3).
  - PS2_DEV_ADDR_NIBBLE=4'hD.
  - PS2_OUT_W=9.
- One sub-module, ps2_fifo: synchronous FIFO, FIFO_DEPTH x 8.
  - Inputs: push, pop, din.
  - Outputs: dout, empty, full, count.
  - Receives the same asynchronous rst.

Test Plan:
- Reset: rst high mid-simulation, then released with ps2_clk/ps2_data idle at 1 -> all outputs 0, fifo_count=0.
- Good frame: send code 0x1C (three ones, parity bit 0, stop 1) -> ps2_out=9'h11C one cycle after the stop-bit fe, fifo_count=1; pulse rd_ack -> ps2_out=9'h000.
- Bad parity: send 0x1C with parity bit 1 -> no push, frame_err high exactly 1 cycle, ps2_out stays 9'h000. Then send 0xF0 with parity 1 -> ps2_out=9'h1F0.
- Timeout: send start + 5 data bits, then hold ps2_clk high for TIMEOUT_CYCLES -> frame_err pulse, FSM back in IDLE. Then send 0x5A (parity 1) -> ps2_out=9'h15A.
- Overflow/full: send 0x01..0x09 with no reads -> fifo_count=8, overflow=1, ps2_out=9'h101. Send 0x0A with rd_ack in the push cycle -> count stays 8, head=0x02, overflow still 1. clr_ovf -> overflow=0.
- Reset mid-frame: assert rst after 4 data bits -> outputs 0 immediately (async). Release and send 0x29 (parity 0) -> ps2_out=9'h129, no frame_err.
